// File: rtl/ysyx_22050243_lsu_pkg.sv
// Shared LSU types: FSM states, RV64 load/store size codes, response error codes.
// Also holds the access-width mask helper used by the lane aligner.
package ysyx_22050243_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    logic [63:0] m;
    case (sz)
      2'b00:   m = 64'h0000_0000_0000_00FF;
      2'b01:   m = 64'h0000_0000_0000_FFFF;
      2'b10:   m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22050243_lsu_align.sv
// Combinational lane logic: request error classification, store lane shift and
// byte mask, and load extract with sign/zero extension. No state, no handshake.
module ysyx_22050243_lsu_align
  import ysyx_22050243_lsu_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata_raw,
  output logic [1:0]  err,
  output logic [63:0] wdata_lane,
  output logic [63:0] wmask,
  output logic [63:0] rdata_ext
);

  logic [5:0]  shamt;
  logic [63:0] rsh;
  logic        illegal;
  logic        misaligned;

  assign shamt      = {addr_lo, 3'b000};
  assign wdata_lane = wdata << shamt;
  assign wmask      = size_mask(funct3[1:0]) << shamt;
  assign rsh        = rdata_raw >> shamt;

  // funct3=111 has no load meaning either, so it is illegal for both directions
  assign illegal = (store && funct3[2]) || (funct3 == 3'b111);

  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = |addr_lo[1:0];
      2'b11:   misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    err = ERR_OK;
    if (illegal)         err = ERR_ILLEGAL;
    else if (misaligned) err = ERR_MISALIGN;
  end

  always_comb begin
    rdata_ext = rsh;
    case (funct3)
      F3_LB:   rdata_ext = {{56{rsh[7]}}, rsh[7:0]};
      F3_LH:   rdata_ext = {{48{rsh[15]}}, rsh[15:0]};
      F3_LW:   rdata_ext = {{32{rsh[31]}}, rsh[31:0]};
      F3_LD:   rdata_ext = rsh;
      F3_LBU:  rdata_ext = {56'd0, rsh[7:0]};
      F3_LHU:  rdata_ext = {48'd0, rsh[15:0]};
      F3_LWU:  rdata_ext = {32'd0, rsh[31:0]};
      default: rdata_ext = rsh;
    endcase
  end

endmodule

// File: rtl/ysyx_22050243_lsu.sv
// Single-outstanding load/store unit: accept in IDLE, one ACCESS phase with timeout,
// result held in RESP until resp_ready. Good access resp_valid at T+2 minimum, errors at T+1.
module ysyx_22050243_lsu
  import ysyx_22050243_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        data_r_en,
  output logic        data_w_en,
  output logic [63:0] data_addr,
  output logic [63:0] data_wmask,
  output logic [63:0] data_w,
  input  logic [63:0] data_r,
  input  logic        data_resp
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state;
  logic [CW-1:0] cnt;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;

  logic        sel_req;
  logic        al_store;
  logic [2:0]  al_funct3;
  logic [2:0]  al_addr_lo;
  logic [63:0] al_wdata;
  logic [1:0]  al_err;
  logic [63:0] al_wdata_lane;
  logic [63:0] al_wmask;
  logic [63:0] al_rdata;

  // The aligner sees the live request while idle (to classify it and build the
  // store lanes) and the captured request afterwards (to extract load data).
  assign sel_req    = (state == ST_IDLE);
  assign al_store   = sel_req ? req_store     : store_q;
  assign al_funct3  = sel_req ? req_funct3    : funct3_q;
  assign al_addr_lo = sel_req ? req_addr[2:0] : addr_q[2:0];
  assign al_wdata   = sel_req ? req_wdata     : wdata_q;

  ysyx_22050243_lsu_align u_align (
    .store      (al_store),
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .wdata      (al_wdata),
    .rdata_raw  (data_r),
    .err        (al_err),
    .wdata_lane (al_wdata_lane),
    .wmask      (al_wmask),
    .rdata_ext  (al_rdata)
  );

  assign data_addr = {addr_q[63:3], 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
      data_r_en  <= 1'b0;
      data_w_en  <= 1'b0;
      data_wmask <= '0;
      data_w     <= '0;
      cnt        <= '0;
      store_q    <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            store_q   <= req_store;
            funct3_q  <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (al_err != ERR_OK) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= al_err;
              resp_rdata <= '0;
            end else begin
              state      <= ST_ACCESS;
              cnt        <= '0;
              data_r_en  <= !req_store;
              data_w_en  <= req_store;
              data_wmask <= req_store ? al_wmask : 64'd0;
              data_w     <= al_wdata_lane;
            end
          end
        end

        ST_ACCESS: begin
          cnt <= cnt + 1'b1;
          // A completion in the final counted cycle still wins over the timeout
          if (data_resp || (cnt == CNT_LAST)) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            data_r_en  <= 1'b0;
            data_w_en  <= 1'b0;
            data_wmask <= '0;
            if (data_resp) begin
              resp_err   <= ERR_OK;
              resp_rdata <= store_q ? 64'd0 : al_rdata;
            end else begin
              resp_err   <= ERR_TIMEOUT;
              resp_rdata <= '0;
            end
          end
        end

        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end

        default: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          data_r_en  <= 1'b0;
          data_w_en  <= 1'b0;
          data_wmask <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
// Directed vector bench for the LSU: table of single transactions plus hand-written
// timeout, backpressure and mid-access reset sequences.
module tb_ysyx_22050243_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        data_r_en, data_w_en;
  logic [63:0] data_addr, data_wmask, data_w, data_r;
  logic        data_resp;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_22050243_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .data_r_en  (data_r_en),
    .data_w_en  (data_w_en),
    .data_addr  (data_addr),
    .data_wmask (data_wmask),
    .data_w     (data_w),
    .data_r     (data_r),
    .data_resp  (data_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] dr;
    logic [1:0]  err;
    logic [63:0] rdata;
    logic [63:0] wmask;
    logic [63:0] w;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(logic st, logic [2:0] f3, logic [63:0] addr, logic [63:0] wdata,
                              logic [63:0] dr, logic [1:0] err, logic [63:0] rdata,
                              logic [63:0] wmask, logic [63:0] w);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.dr = dr;
    v.err = err; v.rdata = rdata; v.wmask = wmask; v.w = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_valid_after_hs", {63'd0, resp_valid}, 64'd0);
    chk("req_ready_after_hs", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    logic [63:0] daddr;
    daddr = {v.addr[63:3], 3'b000};
    issue(v.st, v.f3, v.addr, v.wdata);
    if (v.err != 2'b00) begin
      chk($sformatf("v%0d_err_valid", idx), {63'd0, resp_valid}, 64'd1);
      chk($sformatf("v%0d_err_code", idx), {62'd0, resp_err}, {62'd0, v.err});
      chk($sformatf("v%0d_err_en", idx), {62'd0, data_r_en, data_w_en}, 64'd0);
      chk($sformatf("v%0d_err_rdata", idx), resp_rdata, 64'd0);
    end else begin
      chk($sformatf("v%0d_en", idx), {62'd0, data_r_en, data_w_en}, {62'd0, !v.st, v.st});
      chk($sformatf("v%0d_daddr", idx), data_addr, daddr);
      chk($sformatf("v%0d_wmask", idx), data_wmask, v.wmask);
      if (v.st) chk($sformatf("v%0d_wdata", idx), data_w, v.w);
      chk($sformatf("v%0d_early_valid", idx), {63'd0, resp_valid}, 64'd0);
      data_r = v.dr; data_resp = 1'b1;
      tick();
      data_resp = 1'b0; data_r = 64'd0;
      chk($sformatf("v%0d_valid", idx), {63'd0, resp_valid}, 64'd1);
      chk($sformatf("v%0d_err", idx), {62'd0, resp_err}, 64'd0);
      chk($sformatf("v%0d_rdata", idx), resp_rdata, v.rdata);
      chk($sformatf("v%0d_en_drop", idx), {62'd0, data_r_en, data_w_en}, 64'd0);
      chk($sformatf("v%0d_wmask_drop", idx), data_wmask, 64'd0);
    end
    release_resp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] held;
    logic [63:0] dr0;
    dr0 = 64'h1122_3344_8877_6655;
    //        st    f3      addr                    wdata                   data_r                 err    rdata                   wmask                   w
    vt[0]  = mk(1'b0, 3'b000, 64'h8000_0003, 64'd0, dr0, 2'b00, 64'hFFFF_FFFF_FFFF_FF88, 64'd0, 64'd0);
    vt[1]  = mk(1'b0, 3'b100, 64'h8000_0003, 64'd0, dr0, 2'b00, 64'h0000_0000_0000_0088, 64'd0, 64'd0);
    vt[2]  = mk(1'b0, 3'b001, 64'h8000_0002, 64'd0, dr0, 2'b00, 64'hFFFF_FFFF_FFFF_8877, 64'd0, 64'd0);
    vt[3]  = mk(1'b0, 3'b101, 64'h8000_0006, 64'd0, dr0, 2'b00, 64'h0000_0000_0000_1122, 64'd0, 64'd0);
    vt[4]  = mk(1'b0, 3'b010, 64'h8000_0000, 64'd0, dr0, 2'b00, 64'hFFFF_FFFF_8877_6655, 64'd0, 64'd0);
    vt[5]  = mk(1'b0, 3'b110, 64'h8000_0000, 64'd0, dr0, 2'b00, 64'h0000_0000_8877_6655, 64'd0, 64'd0);
    vt[6]  = mk(1'b0, 3'b010, 64'h8000_0004, 64'd0, dr0, 2'b00, 64'h0000_0000_1122_3344, 64'd0, 64'd0);
    vt[7]  = mk(1'b0, 3'b011, 64'h8000_0008, 64'd0, dr0, 2'b00, dr0, 64'd0, 64'd0);
    vt[8]  = mk(1'b1, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'hDEAD, 2'b00, 64'd0,
                64'hFFFF_0000_0000_0000, 64'hABCD_0000_0000_0000);
    vt[9]  = mk(1'b1, 3'b000, 64'h0000_0001, 64'hFFFF_FFFF_FFFF_FF5A, 64'hBEEF, 2'b00, 64'd0,
                64'h0000_0000_0000_FF00, 64'hFFFF_FFFF_FFFF_5A00);
    vt[10] = mk(1'b1, 3'b010, 64'h0000_0004, 64'h0000_0000_1234_5678, 64'd0, 2'b00, 64'd0,
                64'hFFFF_FFFF_0000_0000, 64'h1234_5678_0000_0000);
    vt[11] = mk(1'b1, 3'b011, 64'h0000_0010, 64'h0123_4567_89AB_CDEF, 64'd0, 2'b00, 64'd0,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF);
    vt[12] = mk(1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 2'b01, 64'd0, 64'd0, 64'd0);
    vt[13] = mk(1'b0, 3'b001, 64'h0000_0001, 64'd0, 64'd0, 2'b01, 64'd0, 64'd0, 64'd0);
    vt[14] = mk(1'b1, 3'b011, 64'h0000_0003, 64'd5, 64'd0, 2'b01, 64'd0, 64'd0, 64'd0);
    vt[15] = mk(1'b1, 3'b100, 64'h0000_0000, 64'd5, 64'd0, 2'b11, 64'd0, 64'd0, 64'd0);
    vt[16] = mk(1'b0, 3'b111, 64'h0000_0000, 64'd0, 64'd0, 2'b11, 64'd0, 64'd0, 64'd0);

    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 64'd0; req_wdata = 64'd0; resp_ready = 1'b0; data_r = 64'd0; data_resp = 1'b0;
    #12;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_en", {62'd0, data_r_en, data_w_en}, 64'd0);
    chk("rst_outs", data_wmask | data_addr | data_w | resp_rdata, 64'd0);
    chk("rst_err", {62'd0, resp_err}, 64'd0);
    #10 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) apply_vec(vt[i], i);

    // Timeout: four ACCESS cycles with enables held, then error response
    issue(1'b0, 3'b011, 64'h20, 64'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_en_c%0d", k), {62'd0, data_r_en, data_w_en}, 64'd2);
      tick();
    end
    chk("to_valid", {63'd0, resp_valid}, 64'd1);
    chk("to_err", {62'd0, resp_err}, 64'd2);
    chk("to_rdata", resp_rdata, 64'd0);
    chk("to_en_drop", {62'd0, data_r_en, data_w_en}, 64'd0);
    data_resp = 1'b1; data_r = 64'h55;
    tick();
    data_resp = 1'b0; data_r = 64'd0;
    chk("to_resp_ignored", {62'd0, resp_err}, 64'd2);
    release_resp();

    // Completion in the last counted cycle beats the timeout
    issue(1'b0, 3'b011, 64'h28, 64'd0);
    tick(); tick(); tick();
    chk("pri_en_still", {62'd0, data_r_en, data_w_en}, 64'd2);
    data_resp = 1'b1; data_r = 64'h0BAD_F00D_1234_5678;
    tick();
    data_resp = 1'b0; data_r = 64'd0;
    chk("pri_err", {62'd0, resp_err}, 64'd0);
    chk("pri_rdata", resp_rdata, 64'h0BAD_F00D_1234_5678);
    release_resp();

    // Backpressure: result held, no new accept while a request waits
    issue(1'b0, 3'b000, 64'h8000_0003, 64'd0);
    data_r = dr0; data_resp = 1'b1;
    tick();
    data_resp = 1'b0; data_r = 64'd0;
    held = resp_rdata;
    chk("bp_first", held, 64'hFFFF_FFFF_FFFF_FF88);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b011; req_addr = 64'h40;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid_c%0d", k), {63'd0, resp_valid}, 64'd1);
      chk($sformatf("bp_rdata_c%0d", k), resp_rdata, 64'hFFFF_FFFF_FFFF_FF88);
      chk($sformatf("bp_req_ready_c%0d", k), {63'd0, req_ready}, 64'd0);
      tick();
    end
    req_valid = 1'b0;
    release_resp();
    chk("bp_no_access", {62'd0, data_r_en, data_w_en}, 64'd0);

    // Reset in the middle of ACCESS, then a stale completion
    issue(1'b1, 3'b011, 64'h48, 64'hCAFE);
    chk("mr_en_before", {62'd0, data_r_en, data_w_en}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_en", {62'd0, data_r_en, data_w_en}, 64'd0);
    chk("mr_outs", data_wmask | data_addr | data_w | resp_rdata, 64'd0);
    chk("mr_req_ready", {63'd0, req_ready}, 64'd1);
    #2 rst_n = 1'b1;
    tick();
    data_resp = 1'b1; data_r = 64'hFFFF;
    tick();
    data_resp = 1'b0; data_r = 64'd0;
    chk("mr_no_valid", {63'd0, resp_valid}, 64'd0);
    tick();
    chk("mr_no_valid2", {63'd0, resp_valid}, 64'd0);
    chk("mr_idle", {63'd0, req_ready}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
